cmd_arb: RTL and testbench

- Sits between the command sources and the command processor.
- Queues BLE commands in a small FIFO and accepts tour-sequencer commands.
- Arbitrates between the two sources and presents one command at a time on cmd/cmd_rdy.
- Tracks which source owns the in-flight command, routes the processor's send_resp back to that source, and discards illegal opcodes so the processor never stalls on them.

---
 rtl/cmd_arb.sv | 189 ++++++++++++++++++
 tb/tb_cmd_arb.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_arb.sv
// Command arbiter: queues BLE commands in a FIFO, arbitrates against the tour
// sequencer, presents one command at a time and routes the response to its owner.
// Optional drop counter port ovf_cnt is enabled by defining CMD_ARB_OVF_CNT_EN.
module cmd_arb #(
  parameter int DEPTH    = 4,
  parameter int TOUR_PRI = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] ble_cmd,
  input  logic        ble_cmd_vld,
  output logic        ble_full,
  output logic        ble_ovf,
  input  logic [15:0] tour_cmd,
  input  logic        tour_cmd_rdy,
  output logic        tour_clr,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic        ble_resp,
  output logic        tour_resp,
  output logic        cmd_err,
  output logic        busy
`ifdef CMD_ARB_OVF_CNT_EN
  ,
  output logic [7:0]  ovf_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESENT   = 2'd1,
    WAIT_RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     mem_q [DEPTH];
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            full_q, full_d;
  logic            ovf_q, ovf_d;
  logic [15:0]     cmd_q, cmd_d;
  logic            owner_q, owner_d;
  logic            bresp_q, bresp_d;
  logic            tresp_q, tresp_d;
  logic            err_q, err_d;

  logic            push, drop, pop;
  logic            ble_avail, sel_tour, sel_ble;
  logic [15:0]     head, sel_word;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      4'b0010, 4'b0100, 4'b0101, 4'b0110: op_legal = 1'b1;
      default:                            op_legal = 1'b0;
    endcase
  endfunction

  // Fullness comes from the registered flag, so a push in the same cycle as a pop while full is dropped.
  assign push      = ble_cmd_vld & ~full_q;
  assign drop      = ble_cmd_vld & full_q;
  assign head      = mem_q[rd_ptr_q];
  assign ble_avail = (count_q != '0);
  assign sel_tour  = tour_cmd_rdy & ((TOUR_PRI != 0) | ~ble_avail);
  assign sel_ble   = ble_avail & ~sel_tour;
  assign sel_word  = sel_tour ? tour_cmd : head;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d = (count_d == CW'(DEPTH));
    ovf_d  = drop;
  end

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    owner_d  = owner_q;
    pop      = 1'b0;
    tour_clr = 1'b0;
    err_d    = 1'b0;
    bresp_d  = 1'b0;
    tresp_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_tour || sel_ble) begin
          cmd_d    = sel_word;
          owner_d  = sel_tour;
          pop      = sel_ble;
          tour_clr = sel_tour & rst_n;
          if (op_legal(sel_word[15:12])) state_d = PRESENT;
          else                           err_d   = 1'b1;
        end
      end
      PRESENT: begin
        if (clr_cmd_rdy) begin
          // Tour start gets no processor response, so completion is signalled right away.
          if (cmd_q[15:12] == 4'b0110) begin
            state_d = IDLE;
            bresp_d = ~owner_q;
            tresp_d = owner_q;
          end else begin
            state_d = WAIT_RESP;
          end
        end
      end
      WAIT_RESP: begin
        if (send_resp) begin
          state_d = IDLE;
          bresp_d = ~owner_q;
          tresp_d = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= ble_cmd;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      cmd_q    <= '0;
      owner_q  <= 1'b0;
      bresp_q  <= 1'b0;
      tresp_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
      cmd_q    <= cmd_d;
      owner_q  <= owner_d;
      bresp_q  <= bresp_d;
      tresp_q  <= tresp_d;
      err_q    <= err_d;
    end
  end

`ifdef CMD_ARB_OVF_CNT_EN
  logic [7:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (bresp_q) ovf_cnt_d = '0;
    if (drop && (ovf_cnt_d != 8'hFF)) ovf_cnt_d = ovf_cnt_d + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ovf_cnt_q <= '0;
    else        ovf_cnt_q <= ovf_cnt_d;
  end

  assign ovf_cnt = ovf_cnt_q;
`endif

  assign ble_full  = full_q;
  assign ble_ovf   = ovf_q;
  assign cmd       = cmd_q;
  assign cmd_rdy   = (state_q == PRESENT);
  assign busy      = (state_q != IDLE);
  assign ble_resp  = bresp_q;
  assign tour_resp = tresp_q;
  assign cmd_err   = err_q;

endmodule

// File: tb/tb_cmd_arb.sv
// Bench for cmd_arb: cycle vector table plus directed multi-cycle sequences.
// Instance 1 uses TOUR_PRI=1, instance 0 uses TOUR_PRI=0.
module tb_cmd_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst_n_t, bvld, bfull, bovf, trdy, tclr, rdy, clr, sresp, bresp, tresp, err, busy;
  logic [1:0][15:0] bcmd, tcmd, cmdo;
`ifdef CMD_ARB_OVF_CNT_EN
  logic [1:0][7:0]  ocnt;
`endif

  cmd_arb #(.DEPTH(4), .TOUR_PRI(1)) dut1 (
    .clk(clk), .rst_n(rst_n_t[1]), .ble_cmd(bcmd[1]), .ble_cmd_vld(bvld[1]),
    .ble_full(bfull[1]), .ble_ovf(bovf[1]), .tour_cmd(tcmd[1]), .tour_cmd_rdy(trdy[1]),
    .tour_clr(tclr[1]), .cmd(cmdo[1]), .cmd_rdy(rdy[1]), .clr_cmd_rdy(clr[1]),
    .send_resp(sresp[1]), .ble_resp(bresp[1]), .tour_resp(tresp[1]), .cmd_err(err[1]),
    .busy(busy[1])
`ifdef CMD_ARB_OVF_CNT_EN
    , .ovf_cnt(ocnt[1])
`endif
  );

  cmd_arb #(.DEPTH(4), .TOUR_PRI(0)) dut0 (
    .clk(clk), .rst_n(rst_n_t[0]), .ble_cmd(bcmd[0]), .ble_cmd_vld(bvld[0]),
    .ble_full(bfull[0]), .ble_ovf(bovf[0]), .tour_cmd(tcmd[0]), .tour_cmd_rdy(trdy[0]),
    .tour_clr(tclr[0]), .cmd(cmdo[0]), .cmd_rdy(rdy[0]), .clr_cmd_rdy(clr[0]),
    .send_resp(sresp[0]), .ble_resp(bresp[0]), .tour_resp(tresp[0]), .cmd_err(err[0]),
    .busy(busy[0])
`ifdef CMD_ARB_OVF_CNT_EN
    , .ovf_cnt(ocnt[0])
`endif
  );

  // Expected-output bits: {cmd_rdy, ble_full, ble_ovf, tour_clr, ble_resp, tour_resp, cmd_err, busy}
  localparam logic [7:0] E_RDY = 8'h80, E_TCLR = 8'h10, E_BR = 8'h08, E_TR = 8'h04,
                         E_ERR = 8'h02, E_BUSY = 8'h01;
  localparam logic [2:0] C_TR = 3'b100, C_CL = 3'b010, C_SR = 3'b001;

  typedef struct {
    logic        r;
    logic [15:0] bc;
    logic        bv;
    logic [15:0] tc;
    logic [2:0]  ctl;
    logic        ck;
    logic [7:0]  e;
    logic [15:0] ec;
  } vec_t;

  vec_t        tv[$];
  int          total = 0;
  int          bad = 0;
  logic [15:0] pres_q[$];
  int          resp_q[$];
  int          tclr_n;

  function automatic vec_t mk(input logic r, input logic [15:0] bc, input logic bv,
                              input logic [15:0] tc, input logic [2:0] ctl, input logic ck,
                              input logic [7:0] e, input logic [15:0] ec);
    vec_t v;
    v.r = r; v.bc = bc; v.bv = bv; v.tc = tc; v.ctl = ctl; v.ck = ck; v.e = e; v.ec = ec;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] pget(input int i);
    if (i < pres_q.size()) return 32'(pres_q[i]);
    return 32'hDEADBEEF;
  endfunction

  function automatic logic [31:0] rget(input int i);
    if (i < resp_q.size()) return 32'(resp_q[i]);
    return 32'hDEADBEEF;
  endfunction

  // Processor and tour-source model: clears every presented command, answers WAIT_RESP
  // on the next cycle, drops tour_cmd_rdy after tour_clr, and logs what it observes.
  task automatic proc_run(input int k, input int ncyc, input logic t0);
    logic tn, prev;
    pres_q.delete(); resp_q.delete(); tclr_n = 0;
    tn = t0; prev = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      bvld[k] = 1'b0; clr[k] = 1'b0; sresp[k] = 1'b0; trdy[k] = tn;
      #1;
      if (tclr[k]) begin tclr_n++; tn = 1'b0; end
      if (rdy[k]) begin
        if (!prev) pres_q.push_back(cmdo[k]);
        clr[k] = 1'b1;
      end
      prev = rdy[k];
      if (busy[k] && !rdy[k]) sresp[k] = 1'b1;
      if (bresp[k]) resp_q.push_back(0);
      if (tresp[k]) resp_q.push_back(1);
    end
  endtask

  // Waits for a presented command, clears it, and returns at the first WAIT_RESP negedge.
  task automatic to_wait(input int k);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      bvld[k] = 1'b0; clr[k] = 1'b0;
      #1;
      if (rdy[k]) begin clr[k] = 1'b1; seen = 1'b1; end
    end
    check($sformatf("to_wait%0d", k), 32'(seen), 32'd1);
    @(negedge clk);
    clr[k] = 1'b0;
  endtask

  task automatic prio(input int k, input logic [15:0] first, input logic [15:0] second,
                      input int first_owner);
    @(negedge clk);
    bcmd[k] = 16'h2000; bvld[k] = 1'b1; tcmd[k] = 16'h5401;
    proc_run(k, 20, 1'b1);
    check($sformatf("prio%0d_npres", k), 32'(pres_q.size()), 32'd2);
    check($sformatf("prio%0d_first", k), pget(0), 32'(first));
    check($sformatf("prio%0d_second", k), pget(1), 32'(second));
    check($sformatf("prio%0d_tclr", k), 32'(tclr_n), 32'd1);
    check($sformatf("prio%0d_resp0", k), rget(0), 32'(first_owner));
    check($sformatf("prio%0d_resp1", k), rget(1), 32'(1 - first_owner));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int ovf_seen;
    logic [7:0] act;
    logic f3, f4;
    int anom;

    rst_n_t = 2'b00; bvld = '0; trdy = '0; clr = '0; sresp = '0; bcmd = '0; tcmd = '0;
    repeat (2) @(negedge clk);
    rst_n_t[0] = 1'b1;

    // Single BLE command, illegal opcode followed by tour start, single tour command.
    tv.push_back(mk(1'b0, 16'h0, 1'b0, 16'h0, 3'b000, 1'b0, 8'h00, 16'h0));
    tv.push_back(mk(1'b0, 16'h0, 1'b0, 16'h0, 3'b000, 1'b1, 8'h00, 16'h0));
    tv.push_back(mk(1'b1, 16'h4023, 1'b1, 16'h0, 3'b000, 1'b1, 8'h00, 16'h0));
    tv.push_back(mk(1'b1, 16'h0, 1'b0, 16'h0, 3'b000, 1'b1, 8'h00, 16'h0));
    for (int j = 0; j < 3; j++)
      tv.push_back(mk(1'b1, 16'h0, 1'b0, 16'h0, 3'b000, 1'b1, E_RDY | E_BUSY, 16'h4023));
    tv.push_back(mk(1'b1, 16'h0, 1'b0, 16'h0, C_CL, 1'b1, E_RDY | E_BUSY, 16'h4023));
    tv.push_back(mk(1'b1, 16'h0, 1'b0, 16'h0, C_CL, 1'b1, E_BUSY, 16'h0));
    for (int j = 0; j < 8; j++)
      tv.push_back(mk(1'b1, 16'h0, 1'b0, 16'h0, 3'b000, 1'b1, E_BUSY, 16'h0));
    tv.push_back(mk(1'b1, 16'h0, 1'b0, 16'h0, C_SR, 1'b1, E_BUSY, 16'h0));
    tv.push_back(mk(1'b1, 16'h0, 1'b0, 16'h0, 3'b000, 1'b1, E_BR, 16'h0));
    tv.push_back(mk(1'b1, 16'h0, 1'b0, 16'h0, C_SR, 1'b1, 8'h00, 16'h0));
    tv.push_back(mk(1'b1, 16'hF123, 1'b1, 16'h0, 3'b000, 1'b1, 8'h00, 16'h0));
    tv.push_back(mk(1'b1, 16'h6000, 1'b1, 16'h0, 3'b000, 1'b1, 8'h00, 16'h0));
    tv.push_back(mk(1'b1, 16'h0, 1'b0, 16'h0, 3'b000, 1'b1, E_ERR, 16'h0));
    tv.push_back(mk(1'b1, 16'h0, 1'b0, 16'h0, C_CL, 1'b1, E_RDY | E_BUSY, 16'h6000));
    tv.push_back(mk(1'b1, 16'h0, 1'b0, 16'h0, 3'b000, 1'b1, E_BR, 16'h0));
    tv.push_back(mk(1'b1, 16'h0, 1'b0, 16'h5401, C_TR, 1'b1, E_TCLR, 16'h0));
    tv.push_back(mk(1'b1, 16'h0, 1'b0, 16'h5401, C_CL, 1'b1, E_RDY | E_BUSY, 16'h5401));
    tv.push_back(mk(1'b1, 16'h0, 1'b0, 16'h0, C_SR, 1'b1, E_BUSY, 16'h0));
    tv.push_back(mk(1'b1, 16'h0, 1'b0, 16'h0, 3'b000, 1'b1, E_TR, 16'h0));
    tv.push_back(mk(1'b1, 16'h0, 1'b0, 16'h0, 3'b000, 1'b1, 8'h00, 16'h0));

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      rst_n_t[1] = tv[i].r; bcmd[1] = tv[i].bc; bvld[1] = tv[i].bv; tcmd[1] = tv[i].tc;
      trdy[1] = tv[i].ctl[2]; clr[1] = tv[i].ctl[1]; sresp[1] = tv[i].ctl[0];
      #1;
      if (tv[i].ck) begin
        act = {rdy[1], bfull[1], bovf[1], tclr[1], bresp[1], tresp[1], err[1], busy[1]};
        check($sformatf("vec%0d_flags", i), 32'(act), 32'(tv[i].e));
        if (tv[i].e[7]) check($sformatf("vec%0d_cmd", i), 32'(cmdo[1]), 32'(tv[i].ec));
      end
    end

    // Priority tie under both settings.
    prio(1, 16'h5401, 16'h2000, 1);
    prio(0, 16'h2000, 16'h5401, 0);

    // Overflow while stalled in WAIT_RESP; pointers start at 1 so the drain wraps.
    @(negedge clk);
    bcmd[1] = 16'h2100; bvld[1] = 1'b1;
    to_wait(1);
    ovf_seen = 0; f3 = 1'b0; f4 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bcmd[1] = 16'h2001 + 16'(i); bvld[1] = 1'b1;
      #1;
      if (i == 3) f3 = bfull[1];
      if (i == 4) f4 = bfull[1];
      if (bovf[1]) ovf_seen++;
      @(negedge clk);
    end
    bvld[1] = 1'b0;
    #1; if (bovf[1]) ovf_seen++;
    @(negedge clk);
    #1; if (bovf[1]) ovf_seen++;
    check("ovf_full_after3", 32'(f3), 32'd0);
    check("ovf_full_after4", 32'(f4), 32'd1);
    check("ovf_pulses", 32'(ovf_seen), 32'd2);
`ifdef CMD_ARB_OVF_CNT_EN
    check("ovf_cnt", 32'(ocnt[1]), 32'd2);
`endif
    sresp[1] = 1'b1;
    proc_run(1, 40, 1'b0);
    check("ovf_npres", 32'(pres_q.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("ovf_word%0d", i), pget(i), 32'h2001 + i);
    check("ovf_full_drained", 32'(bfull[1]), 32'd0);

    // Full FIFO: pop in IDLE coincides with a push, which must be dropped.
    @(negedge clk);
    tcmd[1] = 16'h5401; trdy[1] = 1'b1;
    @(negedge clk);
    trdy[1] = 1'b0;
    to_wait(1);
    for (int i = 0; i < 4; i++) begin
      bcmd[1] = 16'h2011 + 16'(i); bvld[1] = 1'b1;
      @(negedge clk);
    end
    bvld[1] = 1'b0; sresp[1] = 1'b1;
    @(negedge clk);
    sresp[1] = 1'b0; bcmd[1] = 16'h2015; bvld[1] = 1'b1;
    #1;
    check("pp_full_before", 32'(bfull[1]), 32'd1);
    @(negedge clk);
    bvld[1] = 1'b0;
    #1;
    check("pp_ovf", 32'(bovf[1]), 32'd1);
    check("pp_full_after", 32'(bfull[1]), 32'd0);
    check("pp_present", 32'({rdy[1], cmdo[1]}), 32'h1_2011);
    proc_run(1, 40, 1'b0);
    check("pp_npres", 32'(pres_q.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("pp_word%0d", i), pget(i), 32'h2011 + i);

    // Reset while in WAIT_RESP with two words queued.
    @(negedge clk);
    bcmd[1] = 16'h2200; bvld[1] = 1'b1;
    to_wait(1);
    bcmd[1] = 16'h2201; bvld[1] = 1'b1;
    @(negedge clk);
    bcmd[1] = 16'h2202;
    @(negedge clk);
    bvld[1] = 1'b0; rst_n_t[1] = 1'b0;
    @(negedge clk);
    rst_n_t[1] = 1'b1; sresp[1] = 1'b1;
    #1;
    check("rst_busy", 32'(busy[1]), 32'd0);
    check("rst_rdy", 32'(rdy[1]), 32'd0);
    anom = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      sresp[1] = 1'b0;
      #1;
      if (rdy[1] || bresp[1] || busy[1] || bfull[1]) anom++;
    end
    check("rst_quiet", 32'(anom), 32'd0);
    @(negedge clk);
    bcmd[1] = 16'h4000; bvld[1] = 1'b1;
    proc_run(1, 12, 1'b0);
    check("rst_npres", 32'(pres_q.size()), 32'd1);
    check("rst_word", pget(0), 32'h4000);
    check("rst_resp", rget(0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
